debug_interface: RTL and testbench



---
 rtl/debug_pkg.sv | 15 +
 rtl/debug_word_format.sv | 31 +++
 rtl/debug_interface.sv | 41 ++++
 tb/tb_debug_interface.sv | 135 +++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: shared constants for the ALU debug read-out path.
//   DSEL_*  : encodings of the 2-bit debug view select
//   *_W     : fixed field widths (data nibble, opcode, debug word)
package debug_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned DOUT_W = 8;

  localparam logic [1:0] DSEL_RESULT   = 2'b00;
  localparam logic [1:0] DSEL_OPERANDS = 2'b01;
  localparam logic [1:0] DSEL_OPCODE   = 2'b10;
  localparam logic [1:0] DSEL_STATUS   = 2'b11;

endpackage

// File: rtl/debug_word_format.sv
// debug_word_format: combinational formatter for the debug word.
// Ports:
//   Ain, Bin, ALUout : 4-bit unsigned ALU operands / result
//   ALUop            : 3-bit opcode
//   dsel             : view select (result, operands, opcode, status)
//   word             : formatted 8-bit word, all fields zero-extended
module debug_word_format
  import debug_pkg::*;
(
  input  logic [DATA_W-1:0] Ain,
  input  logic [DATA_W-1:0] Bin,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [OP_W-1:0]   ALUop,
  input  logic [1:0]        dsel,
  output logic [DOUT_W-1:0] word
);

  // Only the fields belonging to the selected view reach word, so an
  // unknown value on an unused input cannot leak into the output.
  always_comb begin
    word = '0;
    case (dsel)
      DSEL_RESULT:   word = {4'h0, ALUout};
      DSEL_OPERANDS: word = {Ain, Bin};
      DSEL_OPCODE:   word = {5'b0_0000, ALUop};
      DSEL_STATUS:   word = {1'b0, ALUop, ALUout};
      default:       word = '0;
    endcase
  end

endmodule

// File: rtl/debug_interface.sv
// debug_interface: registered debug read-out multiplexer beside the ALU.
// Passive observer; drives nothing back into the datapath.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low clear of dout
//   Ain    : ALU operand A
//   Bin    : ALU operand B
//   ALUout : ALU result
//   ALUop  : ALU opcode
//   dsel   : debug view select
//   dout   : formatted debug word, driven straight from flops
module debug_interface
  import debug_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Ain,
  input  logic [DATA_W-1:0] Bin,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [OP_W-1:0]   ALUop,
  input  logic [1:0]        dsel,
  output logic [DOUT_W-1:0] dout
);

  logic [DOUT_W-1:0] word;

  debug_word_format u_fmt (
    .Ain    (Ain),
    .Bin    (Bin),
    .ALUout (ALUout),
    .ALUop  (ALUop),
    .dsel   (dsel),
    .word   (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) dout <= '0;
    else        dout <= word;
  end

endmodule

// File: tb/tb_debug_interface.sv
module tb_debug_interface;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Ain, Bin, ALUout;
  logic [2:0] ALUop;
  logic [1:0] dsel;
  logic [7:0] dout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } item_t;

  item_t      sb[$];
  logic [7:0] last_exp;
  bit         have_last = 1'b0;

  always #5 clk = ~clk;

  debug_interface dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Ain    (Ain),
    .Bin    (Bin),
    .ALUout (ALUout),
    .ALUop  (ALUop),
    .dsel   (dsel),
    .dout   (dout)
  );

  // Reference: debug word value as plain arithmetic on the field values.
  function automatic int ref_word(input int sel, input int a, input int b,
                                  input int r, input int op);
    int v;
    if (sel == 0)      v = r;
    else if (sel == 1) v = a * 16 + b;
    else if (sel == 2) v = op;
    else               v = op * 16 + r;
    return v;
  endfunction

  // Drive one cycle of inputs; expected response of the following edge is queued.
  // With junk set, unrelated values appear first and are replaced before the edge.
  task automatic drive(input logic rst, input int a, input int b, input int r,
                       input int op, input int sel, input bit junk,
                       input string name);
    item_t it;
    if (junk) begin
      Ain = 4'($urandom); Bin = 4'($urandom); ALUout = 4'($urandom);
      ALUop = 3'($urandom); dsel = 2'($urandom); rst_n = 1'($urandom);
      #2;
    end
    rst_n = rst; Ain = 4'(a); Bin = 4'(b); ALUout = 4'(r);
    ALUop = 3'(op); dsel = 2'(sel);
    // Output must not react before the clock edge.
    if (have_last) begin
      #1;
      checks++;
      if (dout !== last_exp) begin
        failures++;
        $display("FAIL %s_before_edge: dout=%02h expected=%02h", name, dout, last_exp);
      end
    end
    it.exp  = rst ? 8'(ref_word(sel % 4, a % 16, b % 16, r % 16, op % 8)) : 8'h00;
    it.name = name;
    sb.push_back(it);
    last_exp  = it.exp;
    have_last = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: each edge's result is compared on the following falling edge.
  initial begin
    item_t it;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (dout !== it.exp) begin
          failures++;
          $display("FAIL %s: dout=%02h expected=%02h", it.name, dout, it.exp);
        end
      end
    end
  end

  initial begin
    int a, b, r, op, sel;
    // Reset held for three edges with all-ones inputs.
    for (int i = 0; i < 3; i++) drive(1'b0, 15, 15, 15, 7, 1, 1'b0, "reset_hold");
    drive(1'b1, 15, 15, 15, 7, 1, 1'b0, "reset_release");

    drive(1'b1, 15, 0, 12, 0, 0, 1'b0, "result_view");
    drive(1'b1, 11, 4, 0, 0, 1, 1'b0, "operand_b4");
    drive(1'b1, 7, 8, 0, 0, 1, 1'b0, "operand_78");
    drive(1'b1, 0, 0, 8, 4, 2, 1'b0, "opcode_view");
    drive(1'b1, 0, 0, 8, 4, 3, 1'b0, "status_view");

    // Sweep in steps of 4 with a one-cycle reset pulse in the middle.
    a = 1; b = 2; r = 3; op = 1; sel = 0;
    for (int i = 0; i < 16; i++) begin
      drive((i == 8) ? 1'b0 : 1'b1, a, b, r, op, sel, 1'b0,
            (i == 8) ? "sweep_reset" : "sweep");
      a = (a + 4) % 16; b = (b + 4) % 16; r = (r + 4) % 16;
      op = (op + 4) % 8; sel = (sel + 1) % 4;
    end

    // Randomized traffic, occasional resets and between-edge input noise.
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), 1'($urandom), "random");
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
